// File: rtl/mux_ctrl_pkg.sv
// Shared types and constants for the skewed mux-reset sequencer.
package mux_ctrl_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  function automatic int seq_len(input int n_ch, input int stride, input int block_len);
    return (n_ch - 1) * stride + block_len;
  endfunction

endpackage

// File: rtl/control_mux_skew.sv
// Staggered release of per-channel mux resets so operand rows enter the PE array
// diagonally; optional reverse order, stall and back-to-back repeat.
module control_mux_skew
  import mux_ctrl_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int STRIDE    = 1,
  parameter int BLOCK_LEN = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            dir,
  input  logic            cont,
  input  logic            hold,
  output logic [N_CH-1:0] mux_reset,
  output logic            busy,
  output logic            done
);

  localparam int SEQ_LEN = seq_len(N_CH, STRIDE, BLOCK_LEN);
  localparam int CNT_W   = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SEQ_LEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [N_CH-1:0]   mux_reset_q, mux_reset_d;
  logic              busy_q;
  logic              last_w;

  assign last_w = (state_q == RUN) && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d   = '0;
        dir_d   = dir;
      end
      RUN: if (!hold) begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (cont) dir_d = dir;
          else      state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Windows are built from next-state cnt/dir so the registered lines track cnt_q.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam int KF = i;
    localparam int KR = N_CH - 1 - i;
    localparam logic [CNT_W:0] LO_F = (CNT_W+1)'(KF * STRIDE);
    localparam logic [CNT_W:0] HI_F = (CNT_W+1)'(KF * STRIDE + BLOCK_LEN);
    localparam logic [CNT_W:0] LO_R = (CNT_W+1)'(KR * STRIDE);
    localparam logic [CNT_W:0] HI_R = (CNT_W+1)'(KR * STRIDE + BLOCK_LEN);
    logic [CNT_W:0] c, lo, hi;
    assign c  = {1'b0, cnt_d};
    assign lo = dir_d ? LO_R : LO_F;
    assign hi = dir_d ? HI_R : HI_F;
    assign mux_reset_d[i] = !((state_d == RUN) && (c >= lo) && (c < hi));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      mux_reset_q <= '1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      mux_reset_q <= mux_reset_d;
      busy_q      <= (state_d == RUN);
    end
  end

  assign mux_reset = mux_reset_q;
  assign busy      = busy_q;
  assign done      = last_w && !hold;

endmodule

// File: tb/tb_control_mux_skew.sv
// Directed bench for control_mux_skew at default parameters (SEQ_LEN = 7).
module tb_control_mux_skew;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dir   = 1'b0;
  logic       cont  = 1'b0;
  logic       hold  = 1'b0;
  logic [3:0] mux_reset;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] fwd [7] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0111};
  logic [3:0] rev [7] = '{4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1100, 4'b1110};

  control_mux_skew dut (
    .clock(clock), .reset(reset), .start(start), .dir(dir), .cont(cont), .hold(hold),
    .mux_reset(mux_reset), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] m, input logic b, input logic d);
    #1;
    chk({tag, ".mux"}, 32'(mux_reset), 32'(m));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  initial begin
    int cnt;
    bit seen;

    // asynchronous reset, checked before the first rising edge at t=5
    #2 reset = 1'b0;
    #1;
    chk("rst.mux", 32'(mux_reset), 32'hF);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.done", 32'(done), 32'h0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk_all("idle", 4'b1111, 1'b0, 1'b0);

    // forward run
    start = 1'b1; dir = 1'b0;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk_all($sformatf("fwd%0d", i), fwd[i], 1'b1, i == 6);
      cyc();
    end
    chk_all("fwd.end", 4'b1111, 1'b0, 1'b0);

    // reverse run; a stall on the last count must suppress done
    start = 1'b1; dir = 1'b1;
    cyc();
    start = 1'b0; dir = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin
        hold = 1'b1;
        chk_all("rev.lasthold", rev[6], 1'b1, 1'b0);
        cyc();
        hold = 1'b0;
      end
      chk_all($sformatf("rev%0d", i), rev[i], 1'b1, i == 6);
      cyc();
    end
    chk_all("rev.end", 4'b1111, 1'b0, 1'b0);

    // stall three cycles at cnt=2
    start = 1'b1;
    cyc();
    start = 1'b0;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 20) begin
      cnt++;
      hold = (cnt >= 3 && cnt <= 5);
      #1;
      if (cnt >= 3 && cnt <= 6) chk($sformatf("stall.mux%0d", cnt), 32'(mux_reset), 32'h8);
      seen = done;
      if (!seen) cyc();
    end
    hold = 1'b0;
    chk("stall.done_cycle", 32'(cnt), 32'd10);
    chk("stall.last_mux", 32'(mux_reset), 32'h7);
    cyc();
    chk_all("stall.end", 4'b1111, 1'b0, 1'b0);

    // continuous mode; ignored start mid-run; dropping cont ends after current sequence
    cont = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 7; i++) begin
        if (s == 1 && i == 2) begin start = 1'b1; dir = 1'b1; end
        if (s == 1 && i == 3) begin start = 1'b0; dir = 1'b0; cont = 1'b0; end
        chk_all($sformatf("cont%0d_%0d", s, i), fwd[i], 1'b1, i == 6);
        cyc();
      end
    end
    chk_all("cont.end", 4'b1111, 1'b0, 1'b0);
    cyc();
    chk_all("cont.idle", 4'b1111, 1'b0, 1'b0);

    // mid-run reset at cnt=3
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk_all("mid.cnt3", 4'b0000, 1'b1, 1'b0);
    reset = 1'b0;
    chk_all("mid.rst", 4'b1111, 1'b0, 1'b0);
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all($sformatf("mid.idle%0d", i), 4'b1111, 1'b0, 1'b0);
    end

    // start with hold asserted while idle still launches
    start = 1'b1; hold = 1'b1;
    cyc();
    start = 1'b0; hold = 1'b0;
    chk_all("holdstart", 4'b1110, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
